// File: rtl/vga_pattern_selector.sv
// vga_pattern_selector: maps the sync controller's pixel counters to a 24-bit
// RGB test pattern. A debounced button press advances the pattern, and the
// change is applied only at a frame start so frames are never torn.
// Optional feature macro: PATTERN_GRADIENT_EN adds the GRADIENT pattern.
module vga_pattern_selector #(
    parameter int H_VISIBLE       = 640,
    parameter int V_VISIBLE       = 480,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CHECK_SHIFT     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        swap,
    input  logic [9:0]  hCounter,
    input  logic [9:0]  vCounter,
    output logic [23:0] color,
    output logic [1:0]  pattern,
    output logic        frame_start
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam int             BAR_W    = H_VISIBLE / 8;
    localparam logic [10:0]    H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0]    V_VIS    = 11'(V_VISIBLE);

    typedef enum logic [1:0] {
        BARS     = 2'd0,
        CHECKER  = 2'd1,
        SOLID    = 2'd2,
        GRADIENT = 2'd3
    } pat_t;

    logic          sync1_q, sync2_q;
    logic          acc_q, acc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          press;
    logic          swap_req_q, swap_req_d;
    logic          prev_origin_q;
    logic          at_origin;
    logic          advance;
    pat_t          state_q, state_d;
    logic [23:0]   color_q, color_d;
    logic [2:0]    bar_idx;

    // Two-flop synchroniser for the asynchronous button.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= swap;
            sync2_q <= sync1_q;
        end
    end

    // Debouncer: accept a new level only after a full run of differing samples.
    always_comb begin
        acc_d = acc_q;
        cnt_d = '0;
        press = 1'b0;
        if (sync2_q != acc_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_d = ~acc_q;
                press = ~acc_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debouncer state, pending request and previous-origin flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q         <= 1'b0;
            cnt_q         <= '0;
            swap_req_q    <= 1'b0;
            prev_origin_q <= 1'b0;
        end else begin
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            swap_req_q    <= swap_req_d;
            prev_origin_q <= at_origin;
        end
    end

    // Presses within a frame collapse; a press on the advance cycle stays pending.
    assign swap_req_d  = (swap_req_q & ~advance) | press;
    assign at_origin   = (hCounter == 10'd0) && (vCounter == 10'd0);
    // Gate with reset so the output reads 0 while reset is held.
    assign frame_start = at_origin & ~prev_origin_q & ~reset;
    assign advance     = swap_req_q & frame_start;

    // Pattern state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= BARS;
        else       state_q <= state_d;
    end

    // Pattern next-state: step to the next pattern on a frame-aligned request.
    always_comb begin
        state_d = state_q;
        if (advance) begin
            case (state_q)
                BARS:    state_d = CHECKER;
                CHECKER: state_d = SOLID;
`ifdef PATTERN_GRADIENT_EN
                SOLID:   state_d = GRADIENT;
`else
                SOLID:   state_d = BARS;
`endif
                default: state_d = BARS;
            endcase
        end
    end

    // Bar index from threshold comparisons instead of a divider.
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, hCounter} >= 11'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
        end
    end

    // Colour for the current pixel under the current pattern.
    always_comb begin
        color_d = 24'h000000;
        if (({1'b0, hCounter} < H_VIS) && ({1'b0, vCounter} < V_VIS)) begin
            case (state_q)
                BARS: begin
                    case (bar_idx)
                        3'd0:    color_d = 24'hFFFFFF;
                        3'd1:    color_d = 24'hFFFF00;
                        3'd2:    color_d = 24'h00FFFF;
                        3'd3:    color_d = 24'h00FF00;
                        3'd4:    color_d = 24'hFF00FF;
                        3'd5:    color_d = 24'hFF0000;
                        3'd6:    color_d = 24'h0000FF;
                        default: color_d = 24'h000000;
                    endcase
                end
                CHECKER: color_d = (hCounter[CHECK_SHIFT] ^ vCounter[CHECK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
                SOLID:   color_d = 24'h0000FF;
`ifdef PATTERN_GRADIENT_EN
                GRADIENT: color_d = {hCounter[9:2], vCounter[8:1], 8'h80};
`endif
                default: color_d = 24'h000000;
            endcase
        end
    end

    // Registered colour output, one clock behind the counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) color_q <= 24'h000000;
        else       color_q <= color_d;
    end

    assign color   = color_q;
    assign pattern = state_q;

endmodule

// File: tb/tb_vga_pattern_selector.sv
// Bench for vga_pattern_selector with a short debounce window.
module tb_vga_pattern_selector;

    localparam int DB = 4;
`ifdef PATTERN_GRADIENT_EN
    localparam int NPAT = 4;
`else
    localparam int NPAT = 3;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        swap = 1'b0;
    logic [9:0]  hCounter = 10'd100;
    logic [9:0]  vCounter = 10'd100;
    logic [23:0] color;
    logic [1:0]  pattern;
    logic        frame_start;

    int total = 0;
    int bad   = 0;
    int mpat  = 0;

    vga_pattern_selector #(
        .H_VISIBLE(640), .V_VISIBLE(480), .DEBOUNCE_CYCLES(DB), .CHECK_SHIFT(5)
    ) dut (
        .clk(clk), .reset(reset), .swap(swap),
        .hCounter(hCounter), .vCounter(vCounter),
        .color(color), .pattern(pattern), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int h;
        int v;
        int exp;
    } vec_t;

    // Reference colour straight from the pattern definitions.
    function automatic int ref_color(int h, int v, int pat);
        int bars[8];
        bars = '{32'hFFFFFF, 32'hFFFF00, 32'h00FFFF, 32'h00FF00,
                 32'hFF00FF, 32'hFF0000, 32'h0000FF, 32'h000000};
        if (h >= 640 || v >= 480) return 0;
        case (pat)
            0: return bars[h / 80];
            1: return (((h / 32) + (v / 32)) % 2 == 1) ? 32'hFFFFFF : 0;
            2: return 32'h0000FF;
            default: return (((h / 4) % 256) * 65536) + (((v / 2) % 256) * 256) + 128;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_hv(input int h, input int v);
        hCounter = 10'(h);
        vCounter = 10'(v);
    endtask

    // Press and release, each held well beyond the debounce window.
    task automatic press_clean();
        swap = 1'b1;
        step(DB + 6);
        swap = 1'b0;
        step(DB + 6);
    endtask

    // Frame start with a check of the resulting pattern.
    task automatic do_frame(input string name);
        set_hv(0, 0);
        #1;
        chk({name, "_fs"}, int'(frame_start), 1);
        step();
        chk(name, int'(pattern), mpat);
        set_hv(1, 0);
        step();
    endtask

    task automatic rand_colors(input int n);
        int h, v;
        for (int i = 0; i < n; i++) begin
            h = $urandom_range(1, 700);
            v = $urandom_range(1, 520);
            set_hv(h, v);
            step();
            chk("rand_color", int'(color), ref_color(h, v, mpat));
        end
    endtask

    vec_t bars_tbl[8];

    initial begin
        bars_tbl[0] = '{85, 10, 32'hFFFF00};
        bars_tbl[1] = '{639, 479, 32'h000000};
        bars_tbl[2] = '{640, 10, 32'h000000};
        bars_tbl[3] = '{79, 5, 32'hFFFFFF};
        bars_tbl[4] = '{160, 1, 32'h00FFFF};
        bars_tbl[5] = '{320, 100, 32'hFF00FF};
        bars_tbl[6] = '{559, 200, 32'h0000FF};
        bars_tbl[7] = '{100, 480, 32'h000000};

        // Reset state, including counters at origin during reset.
        step(3);
        set_hv(0, 0);
        #1;
        chk("rst_color", int'(color), 0);
        chk("rst_pattern", int'(pattern), 0);
        chk("rst_fs", int'(frame_start), 0);
        set_hv(100, 100);
        step();
        reset = 1'b0;
        step(2);

        // BARS table.
        foreach (bars_tbl[i]) begin
            set_hv(bars_tbl[i].h, bars_tbl[i].v);
            step();
            chk("bars", int'(color), bars_tbl[i].exp);
        end

        // Short glitch: no press, no advance.
        set_hv(5, 5);
        swap = 1'b1;
        step(DB - 1);
        swap = 1'b0;
        step(10);
        do_frame("glitch");

        // Clean press mid-frame; pattern holds until frame start.
        set_hv(5, 5);
        press_clean();
        chk("hold_pat", int'(pattern), 0);
        set_hv(0, 0);
        #1;
        chk("press_fs", int'(frame_start), 1);
        step();
        mpat = 1;
        chk("press_adv", int'(pattern), mpat);
        chk("fs_once", int'(frame_start), 0);
        step(3);
        chk("fs_held", int'(frame_start), 0);
        chk("pat_held", int'(pattern), mpat);
        set_hv(32, 0);
        step();
        chk("chk_32_0", int'(color), 32'hFFFFFF);
        set_hv(32, 32);
        step();
        chk("chk_32_32", int'(color), 32'h000000);

        // Three presses in one frame give one advance.
        set_hv(5, 5);
        press_clean();
        press_clean();
        press_clean();
        mpat = (mpat + 1) % NPAT;
        do_frame("three_press");
        do_frame("no_extra");

        // Press landing on the frame-start cycle, with a request already pending.
        set_hv(5, 5);
        press_clean();
        swap = 1'b1;
        step(2 + DB - 1);
        mpat = (mpat + 1) % NPAT;
        do_frame("coincide_now");
        step(DB + 4);
        swap = 1'b0;
        step(DB + 6);
        mpat = (mpat + 1) % NPAT;
        do_frame("coincide_next");

        // Reset mid-frame with a pending request.
        set_hv(200, 100);
        press_clean();
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_color", int'(color), 0);
        chk("rst_mid_pat", int'(pattern), 0);
        step();
        reset = 1'b0;
        step(2);
        mpat = 0;
        do_frame("rst_no_adv");

        // Walk through the pattern cycle with random colour checks in each.
        rand_colors(20);
        for (int i = 0; i < 4; i++) begin
            set_hv(5, 5);
            press_clean();
            mpat = (mpat + 1) % NPAT;
            do_frame("cycle");
            set_hv(400, 200);
            step();
            chk("cycle_color", int'(color), ref_color(400, 200, mpat));
            rand_colors(20);
        end
`ifdef PATTERN_GRADIENT_EN
        chk("cycle_end", int'(pattern), 0);
`else
        chk("cycle_end", int'(pattern), 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
